// File: rtl/pipe_ctrl.sv
// Front-end pipeline controller: stall/redirect arbitration with a parked-redirect and post-redirect bubble FSM.
// Optional performance counters are enabled with `define CTRL_PERF_CNT_EN.
module pipe_ctrl #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_req_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              ld_use_i,
   input  logic              div_busy_i,
   input  logic              bus_wait_i,
   output logic              hold_pc_o,
   output logic              hold_if_id_o,
   output logic              hold_id_ex_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
   output logic              pc_jump_o,
   output logic [ADDR_W-1:0] pc_jump_addr_o
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || CNT_W < 1) begin : g_param_chk
      $error("pipe_ctrl: FLUSH_CYCLES must be 1..15 and CNT_W at least 1");
   end

   typedef enum logic [1:0] {RUN, PEND, FLUSH} state_e;

   localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
   logic [3:0]          fcnt_q, fcnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         pend_addr_q <= '0;
         fcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
         fcnt_q      <= fcnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pend_addr_d    = pend_addr_q;
      fcnt_d         = fcnt_q;
      hold_pc_o      = 1'b0;
      hold_if_id_o   = 1'b0;
      hold_id_ex_o   = 1'b0;
      flush_if_id_o  = 1'b0;
      flush_id_ex_o  = 1'b0;
      pc_jump_o      = 1'b0;
      pc_jump_addr_o = pend_addr_q;

      if (rst) begin
         flush_if_id_o  = 1'b1;
         flush_id_ex_o  = 1'b1;
         pc_jump_addr_o = '0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (div_busy_i) begin
                  hold_pc_o    = 1'b1;
                  hold_if_id_o = 1'b1;
                  hold_id_ex_o = 1'b1;
               end else if (jump_req_i && !bus_wait_i) begin
                  pc_jump_o      = 1'b1;
                  pc_jump_addr_o = jump_addr_i;
                  flush_if_id_o  = 1'b1;
                  flush_id_ex_o  = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = FLUSH;
                     fcnt_d  = FCNT_INIT;
                  end
               end else if (jump_req_i) begin
                  pend_addr_d   = jump_addr_i;
                  hold_pc_o     = 1'b1;
                  flush_if_id_o = 1'b1;
                  flush_id_ex_o = 1'b1;
                  state_d       = PEND;
               end else if (ld_use_i) begin
                  hold_pc_o     = 1'b1;
                  hold_if_id_o  = 1'b1;
                  flush_id_ex_o = 1'b1;
               end else if (bus_wait_i) begin
                  hold_pc_o    = 1'b1;
                  hold_if_id_o = 1'b1;
                  hold_id_ex_o = 1'b1;
               end
            end
            PEND: begin
               // EX is fed bubbles while parked, so its requests are don't-care here
               hold_pc_o     = 1'b1;
               flush_if_id_o = 1'b1;
               flush_id_ex_o = 1'b1;
               if (!bus_wait_i) begin
                  pc_jump_o = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_d = FLUSH;
                     fcnt_d  = FCNT_INIT;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            FLUSH: begin
               flush_if_id_o = 1'b1;
               hold_pc_o     = bus_wait_i;
               if (!bus_wait_i) begin
                  fcnt_d = fcnt_q - 4'd1;
                  if (fcnt_q == 4'd1) begin
                     state_d = RUN;
                  end
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (hold_pc_o && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (flush_if_id_o && flush_cnt_q != '1) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the Buceros core front end. It collects stall and redirect requests from fetch, decode and execute, and drives the hold/flush inputs of the PC register and the IF/ID and ID/EX pipeline registers. It also drives the PC redirect (jump) port. It owns a small state machine that parks a redirect while the fetch bus is busy, then inserts a fixed number of bubbles behind every redirect.

## Interface
Parameters:
- ADDR_W, 32, instruction address width; matches `InstAddrBus`.
- FLUSH_CYCLES, 2, bubbles forced into IF/ID after a redirect is issued; legal range 1..15.
- CNT_W, 32, width of the performance counters (used only with the macro).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- jump_req_i  in  1  EX resolved a taken branch/jump; valid only while div_busy_i=0.
- jump_addr_i  in  ADDR_W  redirect target, valid with jump_req_i.
- ld_use_i  in  1  ID detected a load-use hazard.
- div_busy_i  in  1  EX multi-cycle divider occupied.
- bus_wait_i  in  1  fetch bus not ready this cycle.
- hold_pc_o  out  1  freeze PC.
- hold_if_id_o  out  1  freeze IF/ID (drives if_id hold_i).
- hold_id_ex_o  out  1  freeze ID/EX.
- flush_if_id_o  out  1  load NOP into IF/ID.
- flush_id_ex_o  out  1  load NOP into ID/EX.
- pc_jump_o  out  1  PC loads pc_jump_addr_o this cycle.
- pc_jump_addr_o  out  ADDR_W  redirect target.
- stall_cnt_o  out  CNT_W  stall-cycle counter (macro only).
- flush_cnt_o  out  CNT_W  flush-cycle counter (macro only).

## Operation
- States: RUN, PEND (redirect waiting for the fetch bus), FLUSH (post-redirect bubbles). Registers: state, pend_addr[ADDR_W], fcnt[3:0].
- RUN outputs, in priority order:
  1. div_busy_i: hold_pc, hold_if_id and hold_id_ex are all 1.
  2. jump_req_i with bus_wait_i=0:
     - pc_jump_o=1, pc_jump_addr_o=jump_addr_i.
     - flush_if_id_o=1 and flush_id_ex_o=1.
     - Next state is FLUSH with fcnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  3. jump_req_i with bus_wait_i=1:
     - pend_addr<=jump_addr_i.
     - hold_pc=1, flush_if_id=1, flush_id_ex=1.
     - Next state is PEND.
  4. ld_use_i: hold_pc=1, hold_if_id=1, flush_id_ex=1 (one bubble).
  5. bus_wait_i: hold_pc=1, hold_if_id=1, hold_id_ex=1.
  6. Otherwise all outputs are 0.
- PEND:
  - hold_pc=1, flush_if_id=1, flush_id_ex=1 every cycle.
  - ld_use_i, div_busy_i and jump_req_i are ignored (EX holds a bubble).
  - On the first cycle with bus_wait_i=0: pc_jump_o=1, pc_jump_addr_o=pend_addr. Next state is FLUSH or RUN, by the same rule as RUN.
- FLUSH:
  - flush_if_id=1, hold_pc=bus_wait_i.
  - ld_use_i and jump_req_i are ignored.
  - fcnt decrements only in cycles with bus_wait_i=0. When fcnt==1 in such a cycle, the next state is RUN.
- Whenever pc_jump_o=0, pc_jump_addr_o=pend_addr.
- Hold and flush of the same register are never both 1; flush wins by construction.

## Timing
- All outputs are combinational from state and the current inputs. There is no added latency on hold/flush/jump.
- An accepted redirect in RUN is issued in the same cycle as jump_req_i.
- A parked redirect is issued in the first cycle bus_wait_i is sampled low in PEND.
- Reset: while rst=1, flush_if_id_o=1 and flush_id_ex_o=1; all other outputs are 0, and pc_jump_addr_o=0. At the next edge the block enters RUN with pend_addr=0 and fcnt=0.
- rst asserted in PEND or FLUSH discards the parked redirect and the remaining bubbles.
- bus_wait_i dropping in the same cycle jump_req_i arrives counts as bus_wait_i=0 (immediate issue).

## Configuration
- CTRL_PERF_CNT_EN defined:
  - stall_cnt_o increments each cycle hold_pc_o=1.
  - flush_cnt_o increments each cycle flush_if_id_o=1 outside reset.
  - Both counters saturate at all-ones and clear on rst.
- CTRL_PERF_CNT_EN undefined: both ports and both counters are absent. Control behaviour is otherwise identical.

## Test plan
- Reset, then idle with all inputs 0: outputs are 0 from the first post-reset cycle; during rst, flush_if_id_o=1 and flush_id_ex_o=1.
- jump_req_i=1, jump_addr_i=0x8000_0100, bus_wait_i=0, FLUSH_CYCLES=2:
  - Same cycle: pc_jump_o=1, addr 0x8000_0100, both flushes 1.
  - Next cycle: flush_if_id_o=1 only.
  - Then RUN with all outputs 0.
- jump_req_i with addr 0x0000_0040 while bus_wait_i=1 for 3 cycles:
  - PEND holds PC and flushes for 3 cycles.
  - pc_jump_o=1 with 0x0000_0040 in the cycle bus_wait_i falls.
- ld_use_i=1 for one cycle: hold_pc=1, hold_if_id=1, flush_id_ex=1 for exactly that cycle. With div_busy_i=1 simultaneously, all three holds are 1 and flush_id_ex=0.
- rst pulsed in the second PEND cycle, then bus_wait_i=0: no pc_jump_o is ever issued for the discarded redirect.
- With CTRL_PERF_CNT_EN, 5 bus_wait cycles plus one redirect (FLUSH_CYCLES=2): stall_cnt_o=5, flush_cnt_o=2.
